gtxe2_chnl_rx_des_align: RTL
============================

// Module: gtxe2_chnl_rx_des_align
// PURPOSE
//  Single-clock 1:width deserializer with comma detection and word alignment.
//  - Sits in the RX channel between the CDR bit stream and the 8b/10b decoder.
//  - Assembles accepted serial bits into width-bit words; first bit accepted lands in outdata[0].
//  - When enabled, re-aligns word boundaries to a detected comma (PCOMMA/MCOMMA).
// PARAMETERS
//  width          20             output word width, 2..64
//  comma_width    10             comma pattern length, 2..width
//  pcomma_value   10'b0101111100 plus-comma pattern, earliest bit at LSB
//  mcomma_value   10'b1010000011 minus-comma pattern, earliest bit at LSB
//  comma_mask     10'h3FF        1 = bit compared; 0 = don't care
// PORTS
//  clk            in   1      single clock
//  reset_n        in   1      asynchronous, active-low reset
//  indata         in   1      serial data bit
//  in_val         in   1      indata valid this cycle; bit ignored when 0
//  align_en       in   1      1 = realign on comma; 0 = detect only
//  outdata        out  width  assembled word
//  out_val        out  1      1-cycle pulse: outdata holds a new word
//  comma_det      out  1      1-cycle pulse: comma completed on last accepted bit
//  byte_realign   out  1      1-cycle pulse: word boundary moved
//  aligned        out  1      level: boundary locked to a comma
// BEHAVIOUR
//  - Reset, asynchronous on reset_n low: outputs, bit counter cnt, assembly reg and history reg all clear; state UNALIGNED.
//  - Accepted bit: in_val=1 at a rising clk edge. No state changes when in_val=0, except that pulses drop to 0.
//  - Window: win = {bit, hist[comma_width-1:1]}; hist <= win on every accepted bit.
//  - Match: ((win ^ pcomma_value) & comma_mask) == 0, or the same test against mcomma_value.
//  - cnt is 0..width-1 and counts bits already held in the current word.
//  - Normal accept: asm[cnt] <= bit.
//    - If cnt == width-1: outdata <= {bit, asm[width-2:0]}; out_val=1 next cycle; cnt <= 0.
//    - Otherwise cnt <= cnt+1.
//  - Match with align_en=1 and cnt == comma_width-1: boundary is already correct; normal accept.
//  - Match with align_en=1 and cnt != comma_width-1: realign.
//    - asm[comma_width-1:0] <= win; cnt <= comma_width.
//    - Partial word is discarded with no out_val; byte_realign=1.
//    - Special case comma_width == width: the realign emits win as outdata with out_val=1 and cnt <= 0.
//  - comma_det=1 the cycle after any match, regardless of align_en or cnt.
//  - FSM: UNALIGNED -> ALIGNED on the first match with align_en=1 (a realign, or a match with cnt == comma_width-1).
//    - ALIGNED stays ALIGNED on later realigns (byte_realign pulses again).
//    - align_en=0 freezes the boundary and does not change the state.
//    - aligned = (state == ALIGNED).
//  - Latency: outputs are registered; they appear 1 clk after the accepted bit that caused them.
//  - in_val may deassert mid-word; assembly resumes where it left off.
//  - reset_n low mid-word drops the partial word; no out_val is produced for it.
// CONFIGURATION
//  GTXE2_RX_DES_POLARITY_EN defined:
//    - Adds port rxpolarity (in, 1).
//    - When rxpolarity=1, indata is inverted before the window and the assembly logic; comparisons use the inverted bit.
//    - Polarity changes take effect on the next accepted bit.
//  Not defined: port absent; indata used as-is.
// TESTING
//  1. Reset: reset_n=0 with random indata -> all outputs 0, aligned=0.
//  2. Free run, align_en=0, width=20: 40 bits 0..1 alternating -> 2 out_val pulses, outdata=20'hAAAAA each time.
//  3. Realign: align_en=1; 7 junk bits, then 10'b0101111100 (LSB first), then 10'h155.
//     -> comma_det and byte_realign 1 clk after the comma bit.
//     -> aligned=1; next out_val has outdata={10'h155,10'h17C}; no word emitted before it.
//  4. Aligned comma: after test 3, a comma at word bit 0 -> comma_det=1, byte_realign=0, word emitted intact.
//  5. Gapped valid: in_val toggling 1/0 over a 20-bit word -> exactly one out_val, data identical to test 2.
//  6. With GTXE2_RX_DES_POLARITY_EN and rxpolarity=1: inverted comma stream 10'b1010000011 -> detected as pcomma; aligned=1.

Source files
------------

// File: rtl/gtxe2_chnl_rx_des_align.sv
// 1:width deserializer with PCOMMA/MCOMMA detection and word realignment; outputs registered, 1 clk after the accepted bit.
// No backpressure: a bit is taken on every in_val cycle. GTXE2_RX_DES_POLARITY_EN adds the rxpolarity input.
module gtxe2_chnl_rx_des_align #(
  parameter int                     width        = 20,
  parameter int                     comma_width  = 10,
  parameter logic [comma_width-1:0] pcomma_value = 10'b0101111100,
  parameter logic [comma_width-1:0] mcomma_value = 10'b1010000011,
  parameter logic [comma_width-1:0] comma_mask   = 10'h3FF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             indata,
  input  logic             in_val,
  input  logic             align_en,
`ifdef GTXE2_RX_DES_POLARITY_EN
  input  logic             rxpolarity,
`endif
  output logic [width-1:0] outdata,
  output logic             out_val,
  output logic             comma_det,
  output logic             byte_realign,
  output logic             aligned
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] CNT_LAST    = CW'(width - 1);
  localparam logic [CW-1:0] CNT_COMMA   = CW'(comma_width - 1);
  localparam logic [CW-1:0] CNT_REALIGN = (comma_width == width) ? '0 : CW'(comma_width);

  typedef enum logic {UNALIGNED, ALIGNED} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt;
  logic [width-2:0]       asm_reg;
  logic [comma_width-1:1] hist_reg;
  logic                   bit_in;
  logic [comma_width-1:0] win;
  logic                   match;
  logic                   realign;

  always_comb begin
`ifdef GTXE2_RX_DES_POLARITY_EN
    bit_in = indata ^ rxpolarity;
`else
    bit_in = indata;
`endif
    win     = {bit_in, hist_reg};
    match   = (((win ^ pcomma_value) & comma_mask) == '0) ||
              (((win ^ mcomma_value) & comma_mask) == '0);
    realign = in_val && match && align_en && (cnt != CNT_COMMA);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= UNALIGNED;
    else          state_q <= state_d;
  end

  // Any enabled match locks the boundary, whether or not it had to move.
  always_comb begin
    state_d = state_q;
    if (in_val && match && align_en) state_d = ALIGNED;
  end

  assign aligned = (state_q == ALIGNED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      asm_reg      <= '0;
      hist_reg     <= '0;
      outdata      <= '0;
      out_val      <= 1'b0;
      comma_det    <= 1'b0;
      byte_realign <= 1'b0;
    end else begin
      out_val      <= 1'b0;
      comma_det    <= 1'b0;
      byte_realign <= 1'b0;
      if (in_val) begin
        hist_reg  <= win[comma_width-1:1];
        comma_det <= match;
        if (realign) begin
          byte_realign <= 1'b1;
          if (comma_width == width) begin
            outdata <= width'(win);
            out_val <= 1'b1;
            cnt     <= '0;
          end else begin
            // Bits above the comma are rewritten before the word completes.
            asm_reg <= (width-1)'(win);
            cnt     <= CNT_REALIGN;
          end
        end else if (cnt == CNT_LAST) begin
          outdata <= {bit_in, asm_reg};
          out_val <= 1'b1;
          cnt     <= '0;
        end else begin
          asm_reg[cnt] <= bit_in;
          cnt          <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
